// File: rtl/skid_buffer_n.sv
// skid_buffer_n
//
// Purpose:
//   Valid/ready skid buffer placed directly in front of an enabled N-bit
//   stage register. It turns a producer valid/ready stream into a
//   registered data word (out_data) and a valid flag (out_valid). The
//   downstream stage uses these as its d_in / enable pair.
//   in_ready comes only from internal state (and reset), so the ready
//   path is broken. The buffer still sustains one beat per cycle.
//
// Ports:
//   clock        in   rising-edge master clock
//   reset        in   synchronous, active-high; highest priority
//   flush        in   synchronous flush; discards every held beat
//   in_valid     in   producer has a beat on in_data
//   in_ready     out  buffer can accept a beat this cycle
//   in_data      in   [N-1:0] producer data
//   out_valid    out  out_data holds a valid beat
//   out_ready    in   consumer takes out_data this cycle
//   out_data     out  [N-1:0] registered output data (main register)
//   stall_count  out  [STALL_CNT_W-1:0] saturating count of cycles with
//                     out_valid=1 and out_ready=0
//                     (present only when SKID_STALL_CNT_EN is defined)
//
// Configuration macro:
//   SKID_STALL_CNT_EN -- adds the stall_count port and its counter.

module skid_buffer_n #(
    parameter int N           = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_data
`ifdef SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   main_q;
    logic [N-1:0]   main_d;
    logic [N-1:0]   skid_q;
    logic [N-1:0]   skid_d;
    logic           in_fire;
    logic           out_fire;

    // Outputs depend only on registers. The one exception is in_ready,
    // which is also forced low while reset is high.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL) && !reset;
    assign out_data  = main_q;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Next-state and data-load logic.
    // Flush overrides every transfer. An out_fire in the same cycle as a
    // flush has already been taken by the consumer, so nothing more is
    // needed for it here.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d  = in_data;
                    end else if (in_fire) begin
                        // Consumer stalled: park the new beat behind main.
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low in FULL, so only a drain can happen.
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef SKID_STALL_CNT_EN
    // Saturating count of cycles in which a valid beat waits on the
    // consumer. Reset and flush both clear it.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end
`else
    // The counter width has no use without the stall counter.
    logic [STALL_CNT_W-1:0] unused_stall_cnt;
    assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_skid_buffer_n.sv
// tb_skid_buffer_n
//
// Purpose:
//   Self-checking bench for skid_buffer_n.
//   A queue-based model of a two-entry FIFO predicts the outputs. The
//   model's prediction is compared with the DUT on every falling edge.
//   Directed scenarios add hand-computed literal expectations. An
//   in-order sequence scoreboard checks a random valid/ready phase.
//
// Ports: none (top-level bench).
//
// Configuration macro:
//   SKID_STALL_CNT_EN -- also checks stall_count, with STALL_CNT_W = 4.

module tb_skid_buffer_n;

    localparam int N  = 8;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
`ifdef SKID_STALL_CNT_EN
    logic [SW-1:0] stall_count;
`endif

    int total = 0;
    int bad   = 0;
    bit model_live = 1'b0;

    // Model state: the beats held in order (at most 2), the value left in
    // the output register after the last pop, and the stall count.
    logic [N-1:0] mq[$];
    logic [N-1:0] m_last;
    int           m_stall;
    bit           m_in_fire;
    bit           m_out_fire;

    skid_buffer_n #(
        .N          (N),
        .STALL_CNT_W(SW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef SKID_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Behavioural model: a 2-deep FIFO. When it is empty, the visible data
    // is the last beat popped, or 0 after a reset or flush.
    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_last  = '0;
            m_stall = 0;
        end else begin
            m_in_fire  = in_valid && (mq.size() < 2);
            m_out_fire = (mq.size() > 0) && out_ready;
            if (flush) begin
                mq.delete();
                m_last  = '0;
                m_stall = 0;
            end else begin
                if ((mq.size() > 0) && !out_ready && (m_stall < (1 << SW) - 1))
                    m_stall++;
                if (m_out_fire)
                    m_last = mq.pop_front();
                if (m_in_fire)
                    mq.push_back(in_data);
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, on the falling edge.
    always @(negedge clock) begin
        if (model_live) begin
            check("m_out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("m_out_data", 32'(out_data), 32'((mq.size() > 0) ? mq[0] : m_last));
            check("m_in_ready", 32'(in_ready), 32'((mq.size() < 2) && !reset));
`ifdef SKID_STALL_CNT_EN
            check("m_stall_count", 32'(stall_count), 32'(m_stall));
`endif
        end
    end

    int  send;
    int  recv;
    int  cycles;
    bit  acc;
    bit  fire;
    bit  prev_stalled;
    logic [N-1:0] prev_data;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state.
        step();
        step();
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        model_live = 1'b1;
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);

        // Streaming with the consumer always ready: one-cycle latency, no bubbles.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", 32'(out_valid), 32'd0);

        // Back-pressure fill, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        step();
        check("bp_busy_data", 32'(out_data), 32'hA5);
        check("bp_busy_ready", 32'(in_ready), 32'd1);
        in_data = 8'h5A;
        step();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_full_data", 32'(out_data), 32'hA5);
        in_valid = 1'b0;
        step();
        check("bp_hold_data", 32'(out_data), 32'hA5);
        out_ready = 1'b1;
        step();
        check("bp_drain1_data", 32'(out_data), 32'h5A);
        check("bp_drain1_valid", 32'(out_valid), 32'd1);
        step();
        check("bp_drain2_valid", 32'(out_valid), 32'd0);

        // Flush while FULL, with a beat offered in the flush cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        in_data = 8'h22;
        step();
        check("fl_full", 32'(in_ready), 32'd0);
        flush   = 1'b1;
        in_data = 8'h33;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        check("fl_out_data", 32'(out_data), 32'h00);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check("fl_nothing_out", 32'(out_valid), 32'd0);
        end

        // Flush while BUSY with an accepted in_fire: the beat is discarded.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h44;
        step();
        flush   = 1'b1;
        in_data = 8'h55;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_busy_discard", 32'(out_valid), 32'd0);

        // Reset mid-stream while BUSY.
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("rst_mid_ready_low", 32'(in_ready), 32'd0);
        step();
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data", 32'(out_data), 32'h00);
        check("rst_mid_ready_in_rst", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_ready_after", 32'(in_ready), 32'd1);

        // Long stall: the counter saturates, then a flush clears it.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h9C;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        check("stall_data_held", 32'(out_data), 32'h9C);
`ifdef SKID_STALL_CNT_EN
        check("stall_sat", 32'(stall_count), 32'd15);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stall_flush_valid", 32'(out_valid), 32'd0);
`ifdef SKID_STALL_CNT_EN
        check("stall_flush_clr", 32'(stall_count), 32'd0);
`endif

        // Random valid/ready on both sides: 1000 beats, checked in order.
        send         = 0;
        recv         = 0;
        cycles       = 0;
        prev_stalled = 1'b0;
        prev_data    = '0;
        while ((recv < 1000) && (cycles < 30000)) begin
            in_valid  = (send < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = send[7:0];
            out_ready = (send >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (prev_stalled)
                check("rnd_stable", 32'(out_data), 32'(prev_data));
            if (fire) begin
                check("rnd_order", 32'(out_data), 32'(recv[7:0]));
                recv++;
            end
            if (acc)
                send++;
            prev_stalled = out_valid && !out_ready;
            prev_data    = out_data;
            step();
            cycles++;
        end
        check("rnd_count", 32'(recv), 32'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
